// File: rtl/rx_drain_ctrl.sv
// UART receive-side drain controller: acknowledges received bytes into a show-ahead
// FIFO (with framing tag) and keeps saturating framing/overrun edge counters.
//
// state | meaning
// IDLE  | waiting for data_ready with FIFO room; push happens on the leaving edge
// ACK   | byte captured, data_read pulsed once; waiting for data_ready to drop
module rx_drain_ctrl #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_n_rst,
  input  logic [7:0]               i_rx_data,
  input  logic                     i_data_ready,
  input  logic                     i_framing_error,
  input  logic                     i_overrun_error,
  output logic                     o_data_read,
  input  logic                     i_pop,
  output logic [7:0]               o_fifo_data,
  output logic                     o_fifo_frm,
  output logic                     o_fifo_empty,
  output logic                     o_fifo_full,
  output logic [$clog2(DEPTH):0]   o_fifo_count,
  input  logic                     i_clear_counts,
  output logic [CNT_W-1:0]         o_frm_count,
  output logic [CNT_W-1:0]         o_ovr_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  state_t             r_state;
  logic               r_data_read;
  logic [8:0]         r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_count;
  logic               r_frm_prev;
  logic               r_ovr_prev;
  logic [CNT_W-1:0]   r_frm_cnt;
  logic [CNT_W-1:0]   r_ovr_cnt;

  logic               w_push;
  logic               w_pop;
  logic               w_empty;
  logic               w_full;
  logic [8:0]         w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(DEPTH));
  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign w_push  = (r_state == IDLE) && i_data_ready && !w_full;
  assign w_pop   = i_pop && !w_empty;
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_state     <= IDLE;
      r_data_read <= 1'b0;
    end else begin
      r_data_read <= w_push;
      case (r_state)
        IDLE:    if (w_push) r_state <= ACK;
        ACK:     if (!i_data_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {i_framing_error, i_rx_data};
  end

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_frm_prev <= 1'b0;
      r_ovr_prev <= 1'b0;
      r_frm_cnt  <= '0;
      r_ovr_cnt  <= '0;
    end else begin
      r_frm_prev <= i_framing_error;
      r_ovr_prev <= i_overrun_error;
      if (i_clear_counts)
        r_frm_cnt <= '0;
      else if (i_framing_error && !r_frm_prev && (r_frm_cnt != '1))
        r_frm_cnt <= r_frm_cnt + 1'b1;
      if (i_clear_counts)
        r_ovr_cnt <= '0;
      else if (i_overrun_error && !r_ovr_prev && (r_ovr_cnt != '1))
        r_ovr_cnt <= r_ovr_cnt + 1'b1;
    end
  end

  assign o_data_read  = r_data_read;
  assign o_fifo_data  = w_empty ? 8'h00 : w_head[7:0];
  assign o_fifo_frm   = w_empty ? 1'b0 : w_head[8];
  assign o_fifo_empty = w_empty;
  assign o_fifo_full  = w_full;
  assign o_fifo_count = r_count;
  assign o_frm_count  = r_frm_cnt;
  assign o_ovr_count  = r_ovr_cnt;

endmodule

// File: tb/tb_rx_drain_ctrl.sv
// Directed + randomized bench for rx_drain_ctrl, checked every cycle against a
// queue-based model of the receive/ack/FIFO/counter rules.
module tb_rx_drain_ctrl;

  localparam int DEPTH = 8;
  localparam int CNT_W = 8;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       data_ready = 1'b0;
  logic       framing_error = 1'b0;
  logic       overrun_error = 1'b0;
  logic       pop = 1'b0;
  logic       clear_counts = 1'b0;
  logic       data_read;
  logic [7:0] fifo_data;
  logic       fifo_frm;
  logic       fifo_empty;
  logic       fifo_full;
  logic [3:0] fifo_count;
  logic [CNT_W-1:0] frm_count;
  logic [CNT_W-1:0] ovr_count;

  int checks = 0;
  int failures = 0;

  rx_drain_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_n_rst(n_rst), .i_rx_data(rx_data), .i_data_ready(data_ready),
    .i_framing_error(framing_error), .i_overrun_error(overrun_error),
    .o_data_read(data_read), .i_pop(pop), .o_fifo_data(fifo_data), .o_fifo_frm(fifo_frm),
    .o_fifo_empty(fifo_empty), .o_fifo_full(fifo_full), .o_fifo_count(fifo_count),
    .i_clear_counts(clear_counts), .o_frm_count(frm_count), .o_ovr_count(ovr_count)
  );

  always #5 clk = ~clk;

  // Reference model: the FIFO is a queue of {frm,byte}; "captured" means the
  // current data_ready assertion has already delivered its byte.
  logic [8:0] mq[$];
  bit  m_captured, m_ack, m_prev_frm, m_prev_ovr;
  int  m_frm_cnt, m_ovr_cnt, m_pushes;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_captured = 0; m_ack = 0; m_prev_frm = 0; m_prev_ovr = 0;
    m_frm_cnt = 0; m_ovr_cnt = 0;
  endfunction

  task automatic check_model();
    logic [8:0] head;
    head = (mq.size() == 0) ? 9'h000 : mq[0];
    check("data_read", 32'(data_read), 32'(m_ack));
    check("fifo_count", 32'(fifo_count), 32'(mq.size()));
    check("fifo_empty", 32'(fifo_empty), 32'(mq.size() == 0));
    check("fifo_full", 32'(fifo_full), 32'(mq.size() == DEPTH));
    check("fifo_data", 32'(fifo_data), 32'(head[7:0]));
    check("fifo_frm", 32'(fifo_frm), 32'(head[8]));
    check("frm_count", 32'(frm_count), 32'(m_frm_cnt));
    check("ovr_count", 32'(ovr_count), 32'(m_ovr_cnt));
  endtask

  task automatic tick();
    bit push, do_pop, was_full;
    @(posedge clk);
    if (!n_rst) begin
      model_reset();
    end else begin
      was_full = (mq.size() == DEPTH);
      push   = data_ready && !m_captured && !was_full;
      do_pop = pop && (mq.size() != 0);
      if (do_pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back({framing_error, rx_data});
        m_pushes++;
      end
      m_ack = push;
      if (push) m_captured = 1;
      else if (!data_ready) m_captured = 0;
      if (clear_counts) m_frm_cnt = 0;
      else if (framing_error && !m_prev_frm) m_frm_cnt = (m_frm_cnt < 255) ? m_frm_cnt + 1 : 255;
      if (clear_counts) m_ovr_cnt = 0;
      else if (overrun_error && !m_prev_ovr) m_ovr_cnt = (m_ovr_cnt < 255) ? m_ovr_cnt + 1 : 255;
      m_prev_frm = framing_error;
      m_prev_ovr = overrun_error;
    end
    #1;
    check_model();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic f);
    rx_data = d; framing_error = f; data_ready = 1'b1;
    tick();
    data_ready = 1'b0; framing_error = 1'b0;
    tick();
  endtask

  task automatic drain();
    pop = 1'b1;
    for (int i = 0; i < 2 * DEPTH && mq.size() != 0; i++) tick();
    pop = 1'b0;
    check("drain_done", 32'(fifo_count), 32'd0);
  endtask

  initial begin
    model_reset();
    m_pushes = 0;
    tick(); tick();
    n_rst = 1'b1;
    tick();
    check("rst_empty", 32'(fifo_empty), 32'd1);

    // single byte, held ready
    rx_data = 8'hA5; data_ready = 1'b1;
    tick();
    check("single_ack", 32'(data_read), 32'd1);
    check("single_data", 32'(fifo_data), 32'hA5);
    for (int i = 0; i < 3; i++) tick();
    check("single_once", 32'(fifo_count), 32'd1);
    data_ready = 1'b0;
    tick();
    drain();

    // fill to full, then backpressure with a ninth byte
    for (int i = 1; i <= DEPTH; i++) send_byte(8'(i), 1'b0);
    check("fill_full", 32'(fifo_full), 32'd1);
    rx_data = 8'h09; data_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("bp_no_ack", 32'(data_read), 32'd0);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    check("bp_pop_count", 32'(fifo_count), 32'd7);
    tick();
    check("bp_late_push", 32'(fifo_count), 32'd8);
    data_ready = 1'b0;
    tick();
    for (int i = 2; i <= 9; i++) begin
      check("bp_order", 32'(fifo_data), 32'(i));
      pop = 1'b1;
      tick();
      pop = 1'b0;
    end
    check("bp_empty", 32'(fifo_empty), 32'd1);

    // framing tag
    send_byte(8'h3C, 1'b1);
    check("frm_tag", 32'(fifo_frm), 32'd1);
    check("frm_cnt1", 32'(frm_count), 32'd1);
    send_byte(8'h55, 1'b0);
    pop = 1'b1; tick(); pop = 1'b0;
    check("frm_clean_data", 32'(fifo_data), 32'h55);
    check("frm_clean_tag", 32'(fifo_frm), 32'd0);
    drain();

    // push + pop in the same cycle at count 4
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0);
    rx_data = 8'hE7; data_ready = 1'b1; pop = 1'b1;
    tick();
    pop = 1'b0; data_ready = 1'b0;
    check("pushpop_count", 32'(fifo_count), 32'd4);
    tick();

    // randomized traffic: 20 bytes, random pops, wraps pointers
    begin
      int start;
      start = m_pushes;
      for (int cyc = 0; cyc < 3000 && (m_pushes - start) < 20; cyc++) begin
        if (!data_ready) begin
          if ($urandom_range(1, 0) == 1) begin
            rx_data = 8'($urandom); framing_error = 1'($urandom); data_ready = 1'b1;
          end
        end else if (m_captured && $urandom_range(1, 0) == 1) begin
          data_ready = 1'b0; framing_error = 1'b0;
        end
        pop = ($urandom_range(2, 0) == 0);
        tick();
      end
      check("rand_delivered", 32'(m_pushes - start), 32'd20);
    end
    data_ready = 1'b0; framing_error = 1'b0; pop = 1'b0;
    tick();
    drain();
    pop = 1'b1; tick(); pop = 1'b0;
    check("pop_on_empty", 32'(fifo_count), 32'd0);

    // overrun counter saturation and clear priority
    clear_counts = 1'b1; tick(); clear_counts = 1'b0;
    for (int i = 0; i < 300; i++) begin
      overrun_error = 1'b1; tick();
      overrun_error = 1'b0; tick();
    end
    check("ovr_sat", 32'(ovr_count), 32'hFF);
    overrun_error = 1'b1; clear_counts = 1'b1;
    tick();
    clear_counts = 1'b0; overrun_error = 1'b0;
    check("ovr_clear_wins", 32'(ovr_count), 32'd0);
    tick();

    // async reset mid-ACK with 3 entries and nonzero counters
    overrun_error = 1'b1; tick(); overrun_error = 1'b0; tick();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    rx_data = 8'h33; data_ready = 1'b1;
    tick();
    check("pre_rst_count", 32'(fifo_count), 32'd3);
    #3 n_rst = 1'b0;
    #1;
    check("rst_data_read", 32'(data_read), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_empty_async", 32'(fifo_empty), 32'd1);
    check("rst_fifo_data", 32'(fifo_data), 32'd0);
    check("rst_frm_count", 32'(frm_count), 32'd0);
    check("rst_ovr_count", 32'(ovr_count), 32'd0);
    data_ready = 1'b0;
    tick();
    n_rst = 1'b1;
    tick();
    send_byte(8'h44, 1'b0);
    check("post_rst_data", 32'(fifo_data), 32'h44);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
